// File: rtl/pipe_adder_pkg.sv
// pipe_adder_pkg: shared types and helpers for the pipelined adder.
//   stage_t      - per-stage record (beat valid + carry out of the stage)
//   calc_stages  - number of pipeline stages for a WIDTH/CHUNK pair
//   chunk_ok     - elaboration-time legality check of WIDTH/CHUNK
package pipe_adder_pkg;

  typedef struct packed {
    logic vld;
    logic carry;
  } stage_t;

  function automatic int calc_stages(input int w, input int c);
    return w / c;
  endfunction

  function automatic bit chunk_ok(input int w, input int c);
    return (c >= 1) && (w >= c) && ((w % c) == 0);
  endfunction

endpackage

// File: rtl/full_adder.sv
// full_adder: single-bit full adder cell.
//   a_i, b_i, c_i : addends and carry-in
//   s_o, c_o      : sum and carry-out
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

// File: rtl/pipe_adder_slice.sv
// pipe_adder_slice: combinational W-bit ripple of full_adder cells.
//   a_i, b_i : W-bit operand chunks
//   c_i      : carry into bit 0
//   s_o      : W-bit sum chunk
//   c_o      : carry out of bit W-1
//   c_msb_o  : carry into bit W-1 (for signed overflow of the top slice)
module pipe_adder_slice #(
  parameter int W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         c_i,
  output logic [W-1:0] s_o,
  output logic         c_o,
  output logic         c_msb_o
);
  logic [W:0] c;

  assign c[0] = c_i;

  for (genvar i = 0; i < W; i++) begin : g_bit
    full_adder u_fa (
      .a_i(a_i[i]),
      .b_i(b_i[i]),
      .c_i(c[i]),
      .s_o(s_o[i]),
      .c_o(c[i+1])
    );
  end

  assign c_o     = c[W];
  assign c_msb_o = c[W-1];
endmodule

// File: rtl/pipe_adder.sv
// pipe_adder: pipelined WIDTH-bit adder, one CHUNK-bit ripple slice per stage.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : operand beat handshake (a, b, cin)
//   out_valid/out_ready : result handshake (sum, cout, ovf)
//   sum  = a + b + cin mod 2^WIDTH, cout = carry out of MSB,
//   ovf  = carry into MSB ^ carry out of MSB.
// Optional: define PIPE_ADDER_SUB_EN to add input 'sub'; when set the beat
// computes a - b - cin (cout=1 means no borrow, ovf is signed sub overflow).
// Latency is STAGES cycles; a single global enable stalls the whole pipe.
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef PIPE_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int STAGES = calc_stages(WIDTH, CHUNK);

  if (!chunk_ok(WIDTH, CHUNK)) begin : g_bad_cfg
    $error("pipe_adder: WIDTH must be a positive multiple of CHUNK");
  end

  // Subtraction is folded in once at the input: the whole inverted B word
  // travels down the pipe so later stages need no knowledge of 'sub'.
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
`ifdef PIPE_ADDER_SUB_EN
  assign b_eff   = sub ? ~b : b;
  assign cin_eff = sub ? ~cin : cin;
`else
  assign b_eff   = b;
  assign cin_eff = cin;
`endif

  // Stage k register: A word whose chunks 0..k already hold sum bits,
  // the (skewed) B word, and the valid/carry record.
  logic [STAGES-1:0][WIDTH-1:0] a_q, a_d, b_q, b_d;
  stage_t [STAGES-1:0]          st_q, st_d;
  logic                         ovf_q, ovf_d;
  logic                         adv;

  assign adv      = !(st_q[STAGES-1].vld && !out_ready);
  assign in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam logic [WIDTH-1:0] MASK =
      ((WIDTH'(1) << CHUNK) - WIDTH'(1)) << (k * CHUNK);

    logic [WIDTH-1:0] src_a, src_b;
    logic             src_c, src_v;
    logic [CHUNK-1:0] s;
    logic             co, c_msb;

    if (k == 0) begin : g_head
      assign src_a = a;
      assign src_b = b_eff;
      assign src_c = cin_eff;
      assign src_v = in_valid && adv;
    end else begin : g_tail
      assign src_a = a_q[k-1];
      assign src_b = b_q[k-1];
      assign src_c = st_q[k-1].carry;
      assign src_v = st_q[k-1].vld;
    end

    pipe_adder_slice #(.W(CHUNK)) u_slice (
      .a_i    (src_a[k*CHUNK +: CHUNK]),
      .b_i    (src_b[k*CHUNK +: CHUNK]),
      .c_i    (src_c),
      .s_o    (s),
      .c_o    (co),
      .c_msb_o(c_msb)
    );

    // Sum chunk k overwrites operand chunk k of A in the travelling word.
    assign a_d[k]  = (src_a & ~MASK) | (WIDTH'(s) << (k * CHUNK));
    assign b_d[k]  = src_b;
    assign st_d[k] = '{vld: src_v, carry: co};

    if (k == STAGES - 1) begin : g_last
      assign ovf_d = co ^ c_msb;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      st_q  <= '0;
      ovf_q <= 1'b0;
    end else if (adv) begin
      a_q   <= a_d;
      b_q   <= b_d;
      st_q  <= st_d;
      ovf_q <= ovf_d;
    end
  end

  // The last stage's B copy has no consumer.
  logic unused_b;
  assign unused_b = ^b_q[STAGES-1];

  assign out_valid = st_q[STAGES-1].vld;
  assign sum       = a_q[STAGES-1];
  assign cout      = st_q[STAGES-1].carry;
  assign ovf       = ovf_q;
endmodule

// File: tb/tb_pipe_adder.sv
module tb_pipe_adder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 32-bit / 8-bit-chunk instance
  logic        rst, in_valid, in_ready, cin, out_valid, out_ready, cout, ovf, sub_b;
  logic [31:0] a, b, sum;
  // 3-bit / 1-bit-chunk instance
  logic        sv, sr, sci, sov, sor, sco, sof, ssub;
  logic [2:0]  sa, sb, ss;

  pipe_adder #(.WIDTH(32), .CHUNK(8)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
`ifdef PIPE_ADDER_SUB_EN
    .sub(sub_b),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  pipe_adder #(.WIDTH(3), .CHUNK(1)) u_small (
    .clk(clk), .rst(rst), .in_valid(sv), .in_ready(sr),
    .a(sa), .b(sb), .cin(sci),
`ifdef PIPE_ADDER_SUB_EN
    .sub(ssub),
`endif
    .out_valid(sov), .out_ready(sor),
    .sum(ss), .cout(sco), .ovf(sof)
  );

  int tests = 0, fails = 0;
  int got_b = 0, got_s = 0;
  bit mon_en = 1'b0;

  typedef struct {
    logic [31:0] s;
    logic        c;
    logic        o;
  } exp_t;
  exp_t qb[$], qs[$];

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  // Reference: plain integer add on a w-bit word; signed overflow when the
  // addends agree in sign and the result sign differs.
  function automatic exp_t model(input int w, input logic [31:0] x, input logic [31:0] y,
                                 input logic ci, input logic sb_);
    exp_t        r;
    logic [31:0] mask, ye;
    logic [32:0] full;
    logic        ce;
    mask   = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    ye     = (sb_ ? ~y : y) & mask;
    ce     = sb_ ? ~ci : ci;
    full   = {1'b0, x & mask} + {1'b0, ye} + 33'(ce);
    r.s    = full[31:0] & mask;
    r.c    = full[w];
    r.o    = (x[w-1] == ye[w-1]) && (r.s[w-1] != x[w-1]);
    return r;
  endfunction

  always @(negedge clk) if (mon_en) begin
    chk("b_in_ready", in_ready, !(out_valid && !out_ready));
    if (qb.size() == 0) chk("b_out_valid_idle", out_valid, 0);
    else if (out_valid) begin
      chk("b_sum", sum, qb[0].s);
      chk("b_cout", cout, qb[0].c);
      chk("b_ovf", ovf, qb[0].o);
    end
    if (rst) qb.delete();
    else begin
      if (out_valid && out_ready && qb.size() > 0) begin void'(qb.pop_front()); got_b++; end
      if (in_valid && in_ready) qb.push_back(model(32, a, b, cin, sub_b));
    end
  end

  always @(negedge clk) if (mon_en) begin
    chk("s_in_ready", sr, !(sov && !sor));
    if (qs.size() == 0) chk("s_out_valid_idle", sov, 0);
    else if (sov) begin
      chk("s_sum", ss, qs[0].s);
      chk("s_cout", sco, qs[0].c);
      chk("s_ovf", sof, qs[0].o);
    end
    if (rst) qs.delete();
    else begin
      if (sov && sor && qs.size() > 0) begin void'(qs.pop_front()); got_s++; end
      if (sv && sr) qs.push_back(model(3, {29'd0, sa}, {29'd0, sb}, sci, ssub));
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Steps until out_valid (big DUT); n = edges waited after the call.
  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 20) begin step(); n++; end
  endtask

  initial begin
    int n, base, nsent;
    bit acc;
    rst = 1; in_valid = 1; a = 32'hFFFF_FFFF; b = 32'd1; cin = 0; out_ready = 1; sub_b = 0;
    sv = 0; sa = 0; sb = 0; sci = 0; sor = 1; ssub = 0;

    // Reset held 3 cycles with in_valid high
    step(); mon_en = 1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_sum", sum, 0);
      chk("rst_cout", cout, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_s_out_valid", sov, 0);
      if (i < 2) step();
    end
    rst = 0; in_valid = 0;
    repeat (6) begin step(); chk("post_rst_no_beat", out_valid, 0); end

    // Carry through every chunk
    a = 32'hFFFF_FFFF; b = 32'd1; cin = 0; in_valid = 1;
    step(); in_valid = 0;
    wait_out(n);
    chk("lat_carry", n + 1, 4);
    chk("carry_sum", sum, 32'h0000_0000);
    chk("carry_cout", cout, 1);
    chk("carry_ovf", ovf, 0);
    repeat (2) step();

    // Signed overflow, then a back-to-back beat
    a = 32'h7FFF_FFFF; b = 32'd1; cin = 0; in_valid = 1;
    step();
    a = 32'd5; b = 32'd7; cin = 1;
    step(); in_valid = 0;
    wait_out(n);
    chk("lat_b2b", n + 2, 4);
    chk("ovf_sum", sum, 32'h8000_0000);
    chk("ovf_cout", cout, 0);
    chk("ovf_ovf", ovf, 1);
    step();
    chk("b2b_valid", out_valid, 1);
    chk("b2b_sum", sum, 32'h0000_000D);
    chk("b2b_cout", cout, 0);
    chk("b2b_ovf", ovf, 0);
    repeat (3) step();

    // 10 random beats, output stalled for cycles 6..10
    base = got_b; nsent = 0;
    a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1)); in_valid = 1;
    for (int c = 0; c < 60 && (got_b - base) < 10; c++) begin
      out_ready = !(c >= 6 && c <= 10);
      @(negedge clk);
      if (!out_ready && out_valid) chk("stall_in_ready", in_ready, 0);
      acc = in_valid && in_ready;
      step();
      if (acc) begin
        nsent++;
        if (nsent < 10) begin a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1)); end
        else in_valid = 0;
      end
    end
    out_ready = 1; in_valid = 0;
    chk("stream_count", got_b - base, 10);
    chk("stream_left", qb.size(), 0);

    // Reset with 3 beats in flight
    for (int i = 0; i < 3; i++) begin
      a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1)); in_valid = 1;
      step();
    end
    in_valid = 0; rst = 1;
    step(); rst = 0;
    repeat (6) begin chk("flush_out_valid", out_valid, 0); step(); end
    a = 32'h1234_5678; b = 32'h1111_1111; cin = 1; in_valid = 1;
    step(); in_valid = 0;
    wait_out(n);
    chk("lat_after_rst", n + 1, 4);
    chk("after_rst_sum", sum, 32'h2345_678A);
    chk("after_rst_cout", cout, 0);
    repeat (2) step();

    // WIDTH=3, CHUNK=1: every a, b, cin
    base = got_s;
    for (int i = 0; i < 128; i++) begin
      sa = 3'(i); sb = 3'(i >> 3); sci = 1'(i >> 6); sv = 1;
      step();
    end
    sv = 0;
    repeat (6) step();
    chk("small_count", got_s - base, 128);

`ifdef PIPE_ADDER_SUB_EN
    sa = 3'd3; sb = 3'd5; sci = 0; ssub = 1; sv = 1;
    step(); sv = 0;
    n = 0;
    while (!sov && n < 10) begin step(); n++; end
    chk("sub_lat", n + 1, 3);
    chk("sub_sum", ss, 3'd6);
    chk("sub_cout", sco, 0);
    ssub = 0;
    repeat (2) step();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
